// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// uart_cmd_rx : 8N1 UART receiver with "dddd.dd<LF>" parser to packed BCD
// Rev 1.0
// ============================================================================
module uart_cmd_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [23:0] cmd_data,
  output logic        cmd_vld,
  output logic        cmd_err
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TICK = CNT_W'(BAUD_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] P_EMPTY   = 2'd0;
  localparam logic [1:0] P_INT     = 2'd1;
  localparam logic [1:0] P_FRAC    = 2'd2;
  localparam logic [1:0] P_DISCARD = 2'd3;

  logic             rx_meta;
  logic             rx_s;
  logic [1:0]       bit_state;
  logic [1:0]       bit_state_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_r;
  logic             half_tick;
  logic             full_tick;
  logic             cnt_clr;
  logic             data_shift;
  logic             stop_ok;
  logic             stop_bad;
  logic             byte_vld;
  logic             frm_err;

  // Idle-high line: reset the synchroniser to 1 so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign half_tick = (baud_cnt == HALF_TICK);
  assign full_tick = (baud_cnt == FULL_TICK);

  always_ff @(posedge clk) begin
    if (rst) bit_state <= S_IDLE;
    else     bit_state <= bit_state_nxt;
  end

  always_comb begin
    bit_state_nxt = bit_state;
    case (bit_state)
      S_IDLE:  if (!rx_s) bit_state_nxt = S_START;
      S_START: if (half_tick) bit_state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (full_tick && bit_idx == 3'd7) bit_state_nxt = S_STOP;
      S_STOP:  if (full_tick) bit_state_nxt = S_IDLE;
      default: bit_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_clr    = 1'b0;
    data_shift = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (bit_state)
      S_IDLE:  cnt_clr = 1'b1;
      S_START: cnt_clr = half_tick;
      S_DATA: begin
        cnt_clr    = full_tick;
        data_shift = full_tick;
      end
      S_STOP: begin
        cnt_clr  = full_tick;
        stop_ok  = full_tick & rx_s;
        stop_bad = full_tick & ~rx_s;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_r  <= '0;
      byte_vld <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      baud_cnt <= cnt_clr ? '0 : baud_cnt + CNT_W'(1);
      if (bit_state == S_IDLE) begin
        bit_idx <= '0;
      end else if (data_shift) begin
        bit_idx <= bit_idx + 3'd1;
        shift_r <= {rx_s, shift_r[7:1]};
      end
      byte_vld <= stop_ok;
      frm_err  <= stop_bad;
    end
  end

  logic [1:0]  p_state;
  logic [1:0]  p_state_nxt;
  logic [15:0] int_r;
  logic [2:0]  int_cnt;
  logic [7:0]  frac_r;
  logic [1:0]  frac_cnt;
  logic        is_digit;
  logic        is_dot;
  logic        is_cr;
  logic        is_lf;
  logic        in_int;
  logic        line_end;
  logic        has_digit;
  logic        int_shift;
  logic        frac_shift;
  logic        emit_vld;
  logic        emit_err;
  logic [7:0]  frac_field;

  assign is_digit  = (shift_r >= 8'h30) && (shift_r <= 8'h39);
  assign is_dot    = (shift_r == 8'h2E);
  assign is_cr     = (shift_r == 8'h0D);
  assign is_lf     = (shift_r == 8'h0A);
  assign in_int    = (p_state == P_EMPTY) || (p_state == P_INT);
  assign line_end  = byte_vld & is_lf;
  assign has_digit = (int_cnt != 3'd0) || (frac_cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) p_state <= P_EMPTY;
    else     p_state <= p_state_nxt;
  end

  always_comb begin
    p_state_nxt = p_state;
    if (frm_err) begin
      p_state_nxt = P_DISCARD;
    end else if (byte_vld) begin
      if (is_lf) begin
        p_state_nxt = P_EMPTY;
      end else if (is_cr) begin
        p_state_nxt = p_state;
      end else if (is_digit) begin
        if (in_int)
          p_state_nxt = (int_cnt < 3'd4) ? P_INT : P_DISCARD;
        else if (p_state == P_FRAC)
          p_state_nxt = (frac_cnt < 2'd2) ? P_FRAC : P_DISCARD;
      end else if (is_dot) begin
        p_state_nxt = in_int ? P_FRAC : P_DISCARD;
      end else begin
        p_state_nxt = P_DISCARD;
      end
    end
  end

  always_comb begin
    int_shift  = byte_vld & is_digit & in_int & (int_cnt < 3'd4);
    frac_shift = byte_vld & is_digit & (p_state == P_FRAC) & (frac_cnt < 2'd2);
    emit_vld   = line_end & ((p_state == P_INT) | ((p_state == P_FRAC) & has_digit));
    emit_err   = line_end & ((p_state == P_DISCARD) | ((p_state == P_FRAC) & ~has_digit));
    case (frac_cnt)
      2'd2:    frac_field = frac_r;
      2'd1:    frac_field = {frac_r[3:0], 4'h0};
      default: frac_field = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || line_end) begin
      int_r    <= '0;
      int_cnt  <= '0;
      frac_r   <= '0;
      frac_cnt <= '0;
    end else begin
      if (int_shift) begin
        int_r   <= {int_r[11:0], shift_r[3:0]};
        int_cnt <= int_cnt + 3'd1;
      end
      if (frac_shift) begin
        frac_r   <= {frac_r[3:0], shift_r[3:0]};
        frac_cnt <= frac_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_data <= '0;
      cmd_vld  <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_vld <= emit_vld;
      cmd_err <= emit_err;
      if (emit_vld) cmd_data <= {int_r, frac_field};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_cmd_rx : directed serial stimulus against a line-level command model
// Rev 1.0
// ============================================================================
module tb_uart_cmd_rx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int D        = CLK_FREQ / BAUD;
  // start-bit drive cycle to pulse cycle: 2 sync + half bit + 9 bits + byte_vld + parser
  localparam int LAT      = 2 + D / 2 + 9 * D + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [23:0] cmd_data;
  logic        cmd_vld;
  logic        cmd_err;

  uart_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .cmd_data (cmd_data),
    .cmd_vld  (cmd_vld),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          is_err;
    logic [23:0] data;
  } ev_t;

  ev_t         expq[$];
  logic [23:0] model_data = '0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          vld_seen = 0;
  int          err_seen = 0;
  int          last_vld_cyc = 0;
  int          last_lf_cyc  = 0;
  logic [23:0] prev_vld_data = '0;
  logic [23:0] last_vld_data = '0;
  string       line_buf = "";
  bit          line_bad = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Outcome of one line: 0 = silent, 1 = accepted value, 2 = rejected
  function automatic int model_parse(input string s, input bit bad, output logic [23:0] val);
    int     ndots = 0, ilen = 0, flen = 0, nchars = 0;
    bit     ok = 1'b1;
    longint ival = 0, fval = 0;
    logic [7:0] c;
    logic [7:0] fv;
    val = '0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == 8'h0D) continue;
      nchars++;
      if (c == 8'h2E) ndots++;
      else if (c >= 8'h30 && c <= 8'h39) begin
        if (ndots == 0) begin ilen++; ival = ival * 16 + longint'(c - 8'h30); end
        else            begin flen++; fval = fval * 16 + longint'(c - 8'h30); end
      end else ok = 1'b0;
    end
    if (bad) return 2;
    if (nchars == 0) return 0;
    if (!ok || ndots > 1 || ilen > 4 || flen > 2 || (ilen == 0 && flen == 0)) return 2;
    fv  = 8'(fval << (4 * (2 - flen)));
    val = {ival[15:0], fv};
    return 1;
  endfunction

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (D) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_bit);
    int          c;
    int          k;
    logic [23:0] v;
    ev_t         ev;
    c = cyc;
    if (!stop_bit) begin
      line_bad = 1'b1;
    end else if (b == 8'h0A) begin
      last_lf_cyc = c;
      k = model_parse(line_buf, line_bad, v);
      if (k != 0) begin
        ev.due = c + LAT; ev.is_err = (k == 2); ev.data = v;
        expq.push_back(ev);
      end
      line_buf = "";
      line_bad = 1'b0;
    end else begin
      line_buf = $sformatf("%s%c", line_buf, b);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]), 1'b1);
  endtask

  // Per-cycle compare against the event queue
  always @(posedge clk) begin
    bit  exp_v;
    bit  exp_e;
    ev_t ev;
    #1;
    if (rst) begin
      expq.delete();
      model_data = '0;
      check("reset_outputs", {6'd0, cmd_vld, cmd_err, cmd_data}, 32'h0);
    end else begin
      exp_v = 1'b0;
      exp_e = 1'b0;
      if (expq.size() > 0 && expq[0].due == cyc) begin
        ev = expq.pop_front();
        if (ev.is_err) exp_e = 1'b1;
        else begin exp_v = 1'b1; model_data = ev.data; end
      end
      check("cmd_vld", {31'd0, cmd_vld}, {31'd0, exp_v});
      check("cmd_err", {31'd0, cmd_err}, {31'd0, exp_e});
      check("cmd_data", {8'd0, cmd_data}, {8'd0, model_data});
    end
    if (cmd_vld) begin
      vld_seen++;
      last_vld_cyc  = cyc;
      prev_vld_data = last_vld_data;
      last_vld_data = cmd_data;
    end
    if (cmd_err) err_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] v;
    int          k;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * D) @(negedge clk);

    // Model pins
    k = model_parse("123.4\r", 1'b0, v);
    check("model_123.4_kind", k, 1);
    check("model_123.4_val", {8'd0, v}, 32'h012340);
    k = model_parse("5", 1'b1, v);
    check("model_frmerr_kind", k, 2);

    send_str("123.4\r\n");
    repeat (D) @(negedge clk);
    check("t1_data", {8'd0, cmd_data}, 32'h012340);
    check("t1_vld_count", vld_seen, 1);
    check("t1_err_count", err_seen, 0);
    check("t1_latency", last_vld_cyc - last_lf_cyc, 99);

    send_str("9876.54\n");
    send_str("0.05\n");
    repeat (D) @(negedge clk);
    check("t2_first", {8'd0, prev_vld_data}, 32'h987654);
    check("t2_data", {8'd0, cmd_data}, 32'h000005);
    check("t2_vld_count", vld_seen, 3);

    send_str("12345\n");
    send_str("1.234\n");
    send_str("1.2.\n");
    send_str("\n");
    repeat (D) @(negedge clk);
    check("t3_err_count", err_seen, 3);
    check("t3_vld_count", vld_seen, 3);
    check("t3_data_held", {8'd0, cmd_data}, 32'h000005);

    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * D) @(negedge clk);
    check("t4_glitch_err", err_seen, 3);
    check("t4_glitch_vld", vld_seen, 3);
    send_byte(8'h33, 1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_str("5\n");
    repeat (D) @(negedge clk);
    check("t4_err_count", err_seen, 4);
    check("t4_vld_count", vld_seen, 3);
    check("t4_data_held", {8'd0, cmd_data}, 32'h000005);

    // Reset in the middle of the second '7'
    send_byte(8'h37, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rx = 1'b1;
    repeat (D / 2) @(negedge clk);
    rst = 1'b1;
    line_buf = "";
    line_bad = 1'b0;
    @(negedge clk);
    check("t5_rst_data", {8'd0, cmd_data}, 32'h0);
    rst = 1'b0;
    repeat (2 * D) @(negedge clk);
    send_str("42\n");
    repeat (2 * D) @(negedge clk);
    check("t5_data", {8'd0, cmd_data}, 32'h004200);
    check("t5_vld_count", vld_seen, 4);
    check("t5_err_count", err_seen, 4);
    check("queue_drained", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
